// File: rtl/z480_pkg.sv
// Shared Z480 types for the reorder buffer: FSM state, entry payload and size limits.
package z480_pkg;

  localparam int unsigned Z480_ROB_DEPTH_MAX = 256;
  localparam int unsigned Z480_PC_W          = 64;
  localparam int unsigned Z480_PRD_W         = 7;
  localparam int unsigned Z480_CAUSE_W       = 32;

  typedef enum logic {
    Z480_ROB_RUN,
    Z480_ROB_FLUSH
  } z480_rob_state_e;

  typedef struct packed {
    logic                    valid;
    logic                    done;
    logic                    trap;
    logic [Z480_CAUSE_W-1:0] cause;
    logic [Z480_PC_W-1:0]    pc;
    logic                    prd_valid;
    logic [Z480_PRD_W-1:0]   prd;
  } z480_rob_entry_t;

endpackage

// File: rtl/z480_rob_commit_sel.sv
// Retire-lane picker: lanes retire contiguously from the head; a trapping lane is the last one.
module z480_rob_commit_sel #(
  parameter int unsigned COMMIT_W = 2
) (
  input  logic                en,
  input  logic [COMMIT_W-1:0] ent_valid,
  input  logic [COMMIT_W-1:0] ent_done,
  input  logic [COMMIT_W-1:0] ent_trap,
  output logic [COMMIT_W-1:0] lane_valid,
  output logic [COMMIT_W-1:0] lane_trap
);

  // Walk lanes in order; chain closes at the first not-ready or trapping entry.
  always_comb begin : pick
    logic chain;
    lane_valid = '0;
    lane_trap  = '0;
    chain      = en;
    for (int k = 0; k < int'(COMMIT_W); k++) begin
      lane_valid[k] = chain & ent_valid[k] & ent_done[k];
      lane_trap[k]  = lane_valid[k] & ent_trap[k];
      chain         = lane_valid[k] & ~ent_trap[k];
    end
  end

endmodule

// File: rtl/z480_rob_v2.sv
// Z480 P7 in-order-retire reorder buffer: one alloc/cycle, NUM_WB out-of-order
// writebacks, up to COMMIT_W retires/cycle, trap at head turns into commit + flush.
// Optional perf counters enabled by defining Z480_ROB_PERF_EN.
module z480_rob_v2
  import z480_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned NUM_WB   = 2,
  parameter int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [63:0]                  alloc_pc,
  input  logic                         alloc_prd_valid,
  input  logic [6:0]                   alloc_prd,
  output logic [IDX_W-1:0]             alloc_idx,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]      wb_idx,
  input  logic [NUM_WB-1:0]            wb_trap,
  input  logic [NUM_WB*32-1:0]         wb_cause,
  input  logic                         commit_ready,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W*IDX_W-1:0]    commit_idx,
  output logic [COMMIT_W*64-1:0]       commit_pc,
  output logic [COMMIT_W-1:0]          commit_prd_valid,
  output logic [COMMIT_W*7-1:0]        commit_prd,
  output logic [COMMIT_W-1:0]          commit_trap,
  output logic [COMMIT_W*32-1:0]       commit_cause,
  input  logic                         flush,
  output logic [IDX_W:0]               count,
  output logic                         wb_err,
  output logic [31:0]                  perf_retired,
  output logic [31:0]                  perf_full_stall
);

  localparam int unsigned PTR_W = IDX_W + 1;

  z480_rob_state_e  state_q, state_d;
  z480_rob_entry_t  entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W-1:0] count_q;
  logic             wb_err_q;

  logic                full;
  logic                alloc_fire;
  logic                retire_fire;
  logic                trap_retire;
  logic                flush_now;
  logic                wb_en;
  logic [PTR_W-1:0]    retire_cnt;
  logic [IDX_W-1:0]    lane_idx [COMMIT_W];
  logic [COMMIT_W-1:0] ent_valid, ent_done, ent_trap;
  logic [COMMIT_W-1:0] lane_valid, lane_trap;
  logic [IDX_W-1:0]    wb_idx_a [NUM_WB];
  logic [NUM_WB-1:0]   wb_ok, wb_bad;

  // Occupancy and allocation handshake from registered pointers.
  assign full        = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) & (head_q[IDX_W] != tail_q[IDX_W]);
  assign alloc_ready = (state_q == Z480_ROB_RUN) & ~full & ~flush;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_idx   = tail_q[IDX_W-1:0];
  assign count       = count_q;
  assign wb_err      = wb_err_q;

  // Gather status of the COMMIT_W entries starting at head.
  always_comb begin
    ent_valid = '0;
    ent_done  = '0;
    ent_trap  = '0;
    for (int k = 0; k < int'(COMMIT_W); k++) begin
      lane_idx[k]  = head_q[IDX_W-1:0] + IDX_W'(k);
      ent_valid[k] = entries_q[lane_idx[k]].valid;
      ent_done[k]  = entries_q[lane_idx[k]].done;
      ent_trap[k]  = entries_q[lane_idx[k]].trap;
    end
  end

  z480_rob_commit_sel #(
    .COMMIT_W (COMMIT_W)
  ) u_commit_sel (
    .en         (state_q == Z480_ROB_RUN),
    .ent_valid  (ent_valid),
    .ent_done   (ent_done),
    .ent_trap   (ent_trap),
    .lane_valid (lane_valid),
    .lane_trap  (lane_trap)
  );

  // Commit lane payloads, zeroed on idle lanes.
  always_comb begin
    commit_valid     = lane_valid;
    commit_trap      = lane_trap;
    commit_idx       = '0;
    commit_pc        = '0;
    commit_prd_valid = '0;
    commit_prd       = '0;
    commit_cause     = '0;
    for (int k = 0; k < int'(COMMIT_W); k++) begin
      if (lane_valid[k]) begin
        commit_idx[k*IDX_W +: IDX_W] = lane_idx[k];
        commit_pc[k*64 +: 64]        = entries_q[lane_idx[k]].pc;
        commit_prd_valid[k]          = entries_q[lane_idx[k]].prd_valid;
        commit_prd[k*7 +: 7]         = entries_q[lane_idx[k]].prd;
        commit_cause[k*32 +: 32]     = entries_q[lane_idx[k]].cause;
      end
    end
  end

  // Retirement count; external flush suppresses retirement.
  always_comb begin
    retire_fire = (state_q == Z480_ROB_RUN) & commit_ready & ~flush;
    retire_cnt  = '0;
    for (int k = 0; k < int'(COMMIT_W); k++) begin
      if (retire_fire && lane_valid[k]) retire_cnt = retire_cnt + PTR_W'(1);
    end
    trap_retire = retire_fire & (|lane_trap);
    flush_now   = (state_q == Z480_ROB_RUN) & (flush | trap_retire);
  end

  // Writeback qualification: lowest port wins duplicates; stale/invalid targets flag an error.
  always_comb begin
    wb_en  = (state_q == Z480_ROB_RUN) & ~flush;
    wb_ok  = '0;
    wb_bad = '0;
    for (int p = 0; p < int'(NUM_WB); p++) begin
      wb_idx_a[p] = wb_idx[p*IDX_W +: IDX_W];
    end
    for (int p = 0; p < int'(NUM_WB); p++) begin
      logic dup;
      logic live;
      dup = 1'b0;
      for (int q = 0; q < int'(NUM_WB); q++) begin
        if (q < p && wb_valid[q] && wb_idx_a[q] == wb_idx_a[p]) dup = 1'b1;
      end
      live      = entries_q[wb_idx_a[p]].valid & ~entries_q[wb_idx_a[p]].done;
      wb_ok[p]  = wb_en & wb_valid[p] & ~dup & live;
      wb_bad[p] = wb_en & wb_valid[p] & ~dup & ~live;
    end
  end

  // FSM next state: a flush lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Z480_ROB_RUN:   if (flush_now) state_d = Z480_ROB_FLUSH;
      Z480_ROB_FLUSH: state_d = Z480_ROB_RUN;
      default:        state_d = Z480_ROB_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= Z480_ROB_RUN;
    else     state_q <= state_d;
  end

  // Pointers, occupancy and sticky writeback error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      wb_err_q <= wb_err_q | (|wb_bad);
      if (flush_now) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (alloc_fire) tail_q <= tail_q + PTR_W'(1);
        head_q  <= head_q + retire_cnt;
        count_q <= count_q + PTR_W'(alloc_fire) - retire_cnt;
      end
    end
  end

  // Entry storage: writeback marks done, retire clears, alloc installs at tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= '0;
    end else if (flush_now) begin
      for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= '0;
    end else begin
      for (int p = 0; p < int'(NUM_WB); p++) begin
        if (wb_ok[p]) begin
          entries_q[wb_idx_a[p]].done  <= 1'b1;
          entries_q[wb_idx_a[p]].trap  <= wb_trap[p];
          entries_q[wb_idx_a[p]].cause <= wb_cause[p*32 +: 32];
        end
      end
      for (int k = 0; k < int'(COMMIT_W); k++) begin
        if (retire_fire && lane_valid[k]) entries_q[lane_idx[k]] <= '0;
      end
      if (alloc_fire) begin
        entries_q[tail_q[IDX_W-1:0]] <= '{valid:     1'b1,
                                          done:      1'b0,
                                          trap:      1'b0,
                                          cause:     32'h0,
                                          pc:        alloc_pc,
                                          prd_valid: alloc_prd_valid,
                                          prd:       alloc_prd};
      end
    end
  end

`ifdef Z480_ROB_PERF_EN
  logic [31:0] perf_retired_q, perf_full_stall_q;
  logic [32:0] perf_ret_sum;

  assign perf_ret_sum    = {1'b0, perf_retired_q} + 33'(retire_cnt);
  assign perf_retired    = perf_retired_q;
  assign perf_full_stall = perf_full_stall_q;

  // Saturating performance counters; flush leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired_q    <= '0;
      perf_full_stall_q <= '0;
    end else begin
      perf_retired_q <= perf_ret_sum[32] ? 32'hFFFF_FFFF : perf_ret_sum[31:0];
      if (alloc_valid && full && perf_full_stall_q != 32'hFFFF_FFFF)
        perf_full_stall_q <= perf_full_stall_q + 32'd1;
    end
  end
`else
  assign perf_retired    = 32'h0;
  assign perf_full_stall = 32'h0;
`endif

endmodule

// File: tb/tb_z480_rob_v2.sv
// Directed self-checking bench for z480_rob_v2 (DEPTH=8, COMMIT_W=2, NUM_WB=2).
module tb_z480_rob_v2;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 2;
  localparam int unsigned NWB   = 2;
  localparam int unsigned IW    = 3;

`ifdef Z480_ROB_PERF_EN
  localparam logic [31:0] EXP_STALL = 32'd3;
  localparam logic [31:0] EXP_RET   = 32'd21;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_RET   = 32'd0;
`endif

  logic              clk;
  logic              rst;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [63:0]       alloc_pc;
  logic              alloc_prd_valid;
  logic [6:0]        alloc_prd;
  logic [IW-1:0]     alloc_idx;
  logic [NWB-1:0]    wb_valid;
  logic [NWB*IW-1:0] wb_idx;
  logic [NWB-1:0]    wb_trap;
  logic [NWB*32-1:0] wb_cause;
  logic              commit_ready;
  logic [CW-1:0]     commit_valid;
  logic [CW*IW-1:0]  commit_idx;
  logic [CW*64-1:0]  commit_pc;
  logic [CW-1:0]     commit_prd_valid;
  logic [CW*7-1:0]   commit_prd;
  logic [CW-1:0]     commit_trap;
  logic [CW*32-1:0]  commit_cause;
  logic              flush;
  logic [IW:0]       count;
  logic              wb_err;
  logic [31:0]       perf_retired;
  logic [31:0]       perf_full_stall;

  int total = 0;
  int bad   = 0;

  z480_rob_v2 #(.DEPTH(DEPTH), .COMMIT_W(CW), .NUM_WB(NWB)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_prd_valid(alloc_prd_valid), .alloc_prd(alloc_prd), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_trap(wb_trap), .wb_cause(wb_cause),
    .commit_ready(commit_ready), .commit_valid(commit_valid), .commit_idx(commit_idx),
    .commit_pc(commit_pc), .commit_prd_valid(commit_prd_valid), .commit_prd(commit_prd),
    .commit_trap(commit_trap), .commit_cause(commit_cause), .flush(flush),
    .count(count), .wb_err(wb_err),
    .perf_retired(perf_retired), .perf_full_stall(perf_full_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    alloc_valid = 1'b0; alloc_pc = '0; alloc_prd_valid = 1'b0; alloc_prd = '0;
    wb_valid = '0; wb_idx = '0; wb_trap = '0; wb_cause = '0;
    commit_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_alloc(input logic [63:0] pc, input logic [6:0] prd);
    alloc_valid = 1'b1; alloc_pc = pc; alloc_prd_valid = 1'b1; alloc_prd = prd;
  endtask

  task automatic drive_wb(input int p, input logic [IW-1:0] idx, input logic trap, input logic [31:0] cause);
    wb_valid[p] = 1'b1;
    wb_idx[p*IW +: IW] = idx;
    wb_trap[p] = trap;
    wb_cause[p*32 +: 32] = cause;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready got=%0b want=1", alloc_ready); end
    total++; if (alloc_idx !== 3'd0) begin bad++; $display("FAIL reset_alloc_idx got=%0d want=0", alloc_idx); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL reset_commit_valid got=%b want=00", commit_valid); end
    total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL reset_wb_err got=%0b want=0", wb_err); end
    total++; if (perf_retired !== 32'd0 || perf_full_stall !== 32'd0) begin
      bad++; $display("FAIL reset_perf got=%0d/%0d want=0/0", perf_retired, perf_full_stall); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 8; i++) begin
      drive_alloc(64'h1000 + 64'(4 * i), 7'(i));
      total++; if (alloc_idx !== IW'(i)) begin bad++; $display("FAIL fill_idx%0d got=%0d want=%0d", i, alloc_idx, i); end
      total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL fill_ready%0d got=%0b want=1", i, alloc_ready); end
      tick();
    end
    for (int s = 0; s < 3; s++) begin
      total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready%0d got=%0b want=0", s, alloc_ready); end
      tick();
    end
    alloc_valid = 1'b0;
    total++; if (count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d want=8", count); end
    total++; if (perf_full_stall !== EXP_STALL) begin bad++; $display("FAIL perf_full_stall got=%0d want=%0d", perf_full_stall, EXP_STALL); end
  endtask

  task automatic test_flush;
    drive_wb(0, 3'd0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    total++; if (commit_valid !== 2'b01) begin bad++; $display("FAIL flush_pre_commit got=%b want=01", commit_valid); end
    flush = 1'b1; commit_ready = 1'b1;
    drive_alloc(64'hDEAD, 7'h1);
    drive_wb(0, 3'd1, 1'b0, 32'h0);
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL flush_alloc_ready got=%0b want=0", alloc_ready); end
    tick();
    idle_inputs();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", count); end
    total++; if (alloc_ready !== 1'b0 || commit_valid !== 2'b00) begin
      bad++; $display("FAIL flush_state got=ready%0b/cv%b want=ready0/cv00", alloc_ready, commit_valid); end
    total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL flush_wb_err got=%0b want=0", wb_err); end
    tick();
    total++; if (alloc_ready !== 1'b1 || alloc_idx !== 3'd0 || count !== 4'd0) begin
      bad++; $display("FAIL flush_resume got=ready%0b/idx%0d/cnt%0d want=1/0/0", alloc_ready, alloc_idx, count); end
  endtask

  task automatic test_trap;
    for (int i = 0; i < 3; i++) begin
      drive_alloc(64'h2000 + 64'(4 * i), 7'h10 + 7'(i));
      tick();
    end
    idle_inputs();
    drive_wb(0, 3'd1, 1'b1, 32'h0D);
    drive_wb(1, 3'd0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    total++; if (commit_valid !== 2'b11 || commit_trap !== 2'b10) begin
      bad++; $display("FAIL trap_lanes got=cv%b/tr%b want=cv11/tr10", commit_valid, commit_trap); end
    total++; if (commit_idx[2:0] !== 3'd0 || commit_idx[5:3] !== 3'd1) begin
      bad++; $display("FAIL trap_idx got=%0d,%0d want=0,1", commit_idx[2:0], commit_idx[5:3]); end
    total++; if (commit_cause[63:32] !== 32'h0D) begin bad++; $display("FAIL trap_cause got=%0h want=d", commit_cause[63:32]); end
    total++; if (commit_pc[127:64] !== 64'h2004) begin bad++; $display("FAIL trap_pc got=%0h want=2004", commit_pc[127:64]); end
    total++; if (commit_prd[6:0] !== 7'h10 || commit_prd_valid !== 2'b11) begin
      bad++; $display("FAIL trap_prd got=%0h/%b want=10/11", commit_prd[6:0], commit_prd_valid); end
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    total++; if (count !== 4'd0 || alloc_ready !== 1'b0 || commit_valid !== 2'b00) begin
      bad++; $display("FAIL trap_flush got=cnt%0d/ready%0b/cv%b want=0/0/00", count, alloc_ready, commit_valid); end
    total++; if (alloc_idx !== 3'd0) begin bad++; $display("FAIL trap_alloc_idx got=%0d want=0", alloc_idx); end
    tick();
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL trap_resume got=%0b want=1", alloc_ready); end
  endtask

  task automatic test_ooo;
    for (int i = 0; i < 3; i++) begin
      drive_alloc(64'h3000 + 64'(4 * i), 7'h20 + 7'(i));
      tick();
    end
    idle_inputs();
    drive_wb(0, 3'd2, 1'b0, 32'h0);
    tick();
    idle_inputs();
    total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL ooo_wb2 got=%b want=00", commit_valid); end
    drive_wb(0, 3'd0, 1'b0, 32'h0);
    drive_wb(1, 3'd0, 1'b1, 32'h7);
    total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL ooo_wb_latency got=%b want=00", commit_valid); end
    tick();
    idle_inputs();
    total++; if (commit_valid !== 2'b01 || commit_trap !== 2'b00) begin
      bad++; $display("FAIL ooo_wb0 got=cv%b/tr%b want=cv01/tr00", commit_valid, commit_trap); end
    total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL ooo_dup_err got=%0b want=0", wb_err); end
    drive_wb(0, 3'd1, 1'b0, 32'h0);
    tick();
    idle_inputs();
    total++; if (commit_valid !== 2'b11 || commit_idx !== {3'd1, 3'd0}) begin
      bad++; $display("FAIL ooo_wb1 got=cv%b/idx%h want=cv11/idx08", commit_valid, commit_idx); end
    total++; if (commit_pc !== {64'h3004, 64'h3000}) begin bad++; $display("FAIL ooo_pc got=%h want=3004_3000", commit_pc); end
    commit_ready = 1'b1;
    tick();
    total++; if (commit_valid !== 2'b01 || commit_idx[2:0] !== 3'd2 || count !== 4'd1) begin
      bad++; $display("FAIL ooo_second got=cv%b/idx%0d/cnt%0d want=01/2/1", commit_valid, commit_idx[2:0], count); end
    tick();
    commit_ready = 1'b0;
    total++; if (count !== 4'd0 || commit_valid !== 2'b00) begin
      bad++; $display("FAIL ooo_drained got=cnt%0d/cv%b want=0/00", count, commit_valid); end
  endtask

  task automatic test_wrap;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) begin
        drive_alloc(64'h4000 + 64'(4 * i), 7'(i));
        total++; if (alloc_idx !== IW'((3 + i) % 8)) begin
          bad++; $display("FAIL wrap%0d_idx%0d got=%0d want=%0d", pass, i, alloc_idx, (3 + i) % 8); end
        tick();
      end
      idle_inputs();
      total++; if (alloc_ready !== 1'b0 || count !== 4'd8) begin
        bad++; $display("FAIL wrap%0d_full got=ready%0b/cnt%0d want=0/8", pass, alloc_ready, count); end
      for (int j = 0; j < 4; j++) begin
        drive_wb(0, IW'((3 + 2 * j) % 8), 1'b0, 32'h0);
        drive_wb(1, IW'((4 + 2 * j) % 8), 1'b0, 32'h0);
        tick();
      end
      idle_inputs();
      commit_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
        total++; if (commit_valid !== 2'b11 || commit_idx[2:0] !== IW'((3 + 2 * j) % 8) ||
                     commit_idx[5:3] !== IW'((4 + 2 * j) % 8) || count > 4'd8) begin
          bad++; $display("FAIL wrap%0d_retire%0d got=cv%b/idx%h/cnt%0d want=cv11/lanes %0d,%0d",
                          pass, j, commit_valid, commit_idx, count, (3 + 2 * j) % 8, (4 + 2 * j) % 8); end
        tick();
      end
      commit_ready = 1'b0;
      total++; if (count !== 4'd0 || alloc_ready !== 1'b1 || commit_valid !== 2'b00) begin
        bad++; $display("FAIL wrap%0d_empty got=cnt%0d/ready%0b/cv%b want=0/1/00", pass, count, alloc_ready, commit_valid); end
    end
    total++; if (perf_retired !== EXP_RET) begin bad++; $display("FAIL perf_retired got=%0d want=%0d", perf_retired, EXP_RET); end
  endtask

  task automatic test_wb_err;
    drive_wb(0, 3'd5, 1'b0, 32'h0);
    tick();
    idle_inputs();
    total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL wb_err_set got=%0b want=1", wb_err); end
    total++; if (count !== 4'd0 || commit_valid !== 2'b00 || alloc_idx !== 3'd3) begin
      bad++; $display("FAIL wb_err_state got=cnt%0d/cv%b/idx%0d want=0/00/3", count, commit_valid, alloc_idx); end
    tick(); tick();
    total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL wb_err_sticky got=%0b want=1", wb_err); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_flush();
    test_trap();
    test_ooo();
    test_wrap();
    test_wb_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
